// File: rtl/tb_obi_mem_arbiter_pkg.sv
// Purpose: shared types and constants for the OBI memory arbiter slice.
//   owner_e    - which master issued an outstanding transaction
//   LFSR_SEED  - reset value of the optional stall-injection LFSR
//   LFSR_TAPS  - feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
// Optional feature macro: CV32E40P_TB_ARB_STALL_EN (consumer: tb_obi_mem_arbiter).
package tb_obi_arb_pkg;

  typedef enum logic {OWNER_INSTR = 1'b0, OWNER_DATA = 1'b1} owner_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/tb_obi_mem_arbiter_if.sv
// Purpose: bundles the fetch, data and memory OBI buses around the arbiter.
//   slave  modport - the arbiter's view (takes master requests and memory
//                    responses, drives grants, memory request and responses)
//   master modport - the surrounding environment's view (core + RAM model)
// Parameter: ADDR_WIDTH - address width on all three buses.
interface tb_obi_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  // fetch bus
  logic                  instr_req_i;
  logic                  instr_gnt_o;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_rvalid_o;
  logic [31:0]           instr_rdata_o;
  // data bus
  logic                  data_req_i;
  logic                  data_gnt_o;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic                  data_we_i;
  logic [3:0]            data_be_i;
  logic [31:0]           data_wdata_i;
  logic                  data_rvalid_o;
  logic [31:0]           data_rdata_o;
  // shared memory port
  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_rvalid_i;
  logic [31:0]           mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/tb_obi_owner_fifo.sv
// Purpose: in-order record of which master owns each outstanding memory
// transaction. Pointers carry one extra wrap bit so full/empty are exact.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears pointers)
//   push       - append push_owner (ignored when full)
//   pop        - drop head (ignored when empty)
//   head       - owner of the oldest outstanding transaction
//   empty/full - occupancy flags
//   count      - occupancy, zero-extended to 4 bits
module tb_obi_owner_fifo
  import tb_obi_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  owner_e     push_owner,
  input  logic       pop,
  output owner_e     head,
  output logic       empty,
  output logic       full,
  output logic [3:0] count
);

  localparam int PW = $clog2(DEPTH) + 1;
  // DEPTH=1 has no index bits; keep a 1-bit index that is always masked to 0.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  owner_e          slots [2**IW];
  logic [PW-1:0]   wptr, rptr, diff;
  logic [IW-1:0]   wr_idx, rd_idx;

  assign wr_idx = IW'(wptr & PW'(DEPTH - 1));
  assign rd_idx = IW'(rptr & PW'(DEPTH - 1));

  assign empty = (wptr == rptr);
  // full: wrap bits differ and index bits match, i.e. XOR equals just the MSB
  assign full  = ((wptr ^ rptr) == PW'(DEPTH));
  assign diff  = wptr - rptr;
  assign count = 4'(diff);
  assign head  = slots[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop  && !empty) rptr <= rptr + 1'b1;
    end
  end

  // payload needs no reset: a slot is only read after it has been written
  always_ff @(posedge clk) begin
    if (push && !full) slots[wr_idx] <= push_owner;
  end

endmodule

// File: rtl/tb_obi_mem_arbiter.sv
// Purpose: shares one single-ported OBI memory between the fetch and data
// masters. Round-robin on contention (priority rotates only on a memory
// handshake), owner FIFO records issue order so in-order responses go back
// to the right master in the same cycle they arrive.
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   stall_en_i    - (CV32E40P_TB_ARB_STALL_EN only) enables random stalls
//   bus           - fetch/data/memory buses (tb_obi_mem_arbiter_if.slave)
//   outstanding_o - granted-but-unanswered transactions
//   err_o         - sticky: a response arrived with nothing outstanding
// Optional feature macro: CV32E40P_TB_ARB_STALL_EN -- a 16-bit LFSR blocks
// issue on cycles where its two LSBs are zero, for grant-stall stress.
module tb_obi_mem_arbiter
  import tb_obi_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
`ifdef CV32E40P_TB_ARB_STALL_EN
  input  logic                     stall_en_i,
`endif
  tb_obi_mem_arbiter_if.slave      bus,
  output logic [3:0]               outstanding_o,
  output logic                     err_o
);

  owner_e                last_winner, sel, head;
  logic                  fifo_empty, fifo_full;
  logic                  stall, can_issue, handshake, pop;
  logic [ADDR_WIDTH-1:0] sel_addr;

`ifdef CV32E40P_TB_ARB_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign stall = stall_en_i && (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // FIFO depth equals MAX_OUTSTANDING, so "not full" is "outstanding < MAX".
  // A slot freed by this cycle's response is only usable next cycle.
  assign can_issue = !fifo_full && !stall;

  always_comb begin
    sel = OWNER_INSTR;
    if (bus.instr_req_i && bus.data_req_i)
      sel = (last_winner == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
    else if (bus.data_req_i)
      sel = OWNER_DATA;
  end

  assign sel_addr        = (sel == OWNER_DATA) ? bus.data_addr_i : bus.instr_addr_i;
  assign bus.mem_req_o   = can_issue && (bus.instr_req_i || bus.data_req_i);
  assign bus.mem_addr_o  = sel_addr;
  assign bus.mem_we_o    = (sel == OWNER_DATA) ? bus.data_we_i    : 1'b0;
  assign bus.mem_be_o    = (sel == OWNER_DATA) ? bus.data_be_i    : 4'hF;
  assign bus.mem_wdata_o = (sel == OWNER_DATA) ? bus.data_wdata_i : 32'h0;

  assign handshake      = bus.mem_req_o && bus.mem_gnt_i;
  assign bus.instr_gnt_o = handshake && (sel == OWNER_INSTR);
  assign bus.data_gnt_o  = handshake && (sel == OWNER_DATA);

  // a response with nothing outstanding is dropped and flagged
  assign pop               = bus.mem_rvalid_i && !fifo_empty;
  assign bus.instr_rvalid_o = pop && (head == OWNER_INSTR);
  assign bus.data_rvalid_o  = pop && (head == OWNER_DATA);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;

  // reset to INSTR so data wins the first contention
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_winner <= OWNER_INSTR;
      err_o       <= 1'b0;
    end else begin
      if (handshake) last_winner <= sel;
      if (bus.mem_rvalid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  tb_obi_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (handshake),
    .push_owner (sel),
    .pop        (pop),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (outstanding_o)
  );

endmodule

// File: doc/tb_obi_mem_arbiter.md
Name: tb_obi_mem_arbiter

Overview:
- Shares one single-ported OBI memory port between the core's instruction-fetch and data OBI masters in the example testbench subsystem.
- Arbitrates round-robin and tracks outstanding transactions in an owner FIFO. Routes each in-order response (rvalid/rdata) back to the master that issued it.
- Sits between the core wrapper's instr_*/data_* buses and a single-port RAM model.

Parameters:
- MAX_OUTSTANDING, 2, max granted-but-unanswered transactions; power of two, range 1..8.
- ADDR_WIDTH, 32, address width on all ports.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch grant
- instr_addr_i  in  ADDR_WIDTH  fetch address
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant
- data_addr_i  in  ADDR_WIDTH  data address
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_wdata_o  out  32  memory write data
- mem_rvalid_i  in  1  memory response valid (in order)
- mem_rdata_i  in  32  memory read data
- outstanding_o  out  4  current owner-FIFO occupancy
- err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous, active-high.
- State after reset: FIFO empty, outstanding_o=0, err_o=0, last_winner=INSTR (so data wins the first contention).
- Masters follow OBI rules: a request holds req/addr/we/be/wdata stable until granted.
- Issue condition: can_issue = (outstanding < MAX_OUTSTANDING). There is no same-cycle pop bypass; a slot freed by rvalid is usable the next cycle.
- Selection (combinational):
  - Only one master requesting: that master is selected.
  - Both requesting: the master that is not last_winner is selected.
- Memory request: mem_req_o = can_issue & (instr_req_i | data_req_i).
  - mem_addr_o/we/be/wdata are muxed from the selected master.
  - Instruction requests drive we=0, be=4'hF, wdata=0.
- Grants: x_gnt_o = mem_gnt_i & mem_req_o & selected==x. At most one grant per cycle. Zero-cycle latency from mem_gnt_i to the master grant.
- On handshake (mem_req_o & mem_gnt_i):
  - push the owner ID into the FIFO;
  - last_winner <= selected.
- last_winner changes only on handshake. A request that is not granted does not rotate priority.
- Response routing: on mem_rvalid_i, pop the FIFO head and assert x_rvalid_o for head owner x in the same cycle. rdata passes through to both rdata outputs unchanged.
- Simultaneous push and pop: occupancy unchanged, both operations take effect.
- Error: mem_rvalid_i while the FIFO is empty sets err_o=1 (sticky until reset). The response is dropped and the pointers are unchanged.
- Wrap-around: FIFO pointers are log2(MAX_OUTSTANDING)+1 bits. Full when the MSBs differ and the low bits are equal.
- Reset mid-transaction: FIFO cleared and in-flight responses forgotten. The memory model must be reset concurrently.

Optional Feature:
- Macro: CV32E40P_TB_ARB_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - When lfsr[1:0]==2'b00, can_issue is forced low that cycle, giving random grant stalls for stress.
  - Adds input stall_en_i (1 bit) gating the injection.
- Undefined: no LFSR, no stall_en_i port, behaviour exactly as above.

Decomposition:
- Package tb_obi_arb_pkg:
  - typedef enum logic {OWNER_INSTR=1'b0, OWNER_DATA=1'b1} owner_e;
  - LFSR seed and tap constants.
- Sub-module tb_obi_owner_fifo:
  - parameterised depth, owner_e payload;
  - ports push/pop/head/empty/full/count.
- The arbiter instantiates it once.

Test Plan:
- Single fetch: instr_req_i=1 addr 0x180, mem_gnt_i=1, rvalid next cycle with rdata 0xDEADBEEF -> instr_gnt_o same cycle, instr_rvalid_o=1 with rdata 0xDEADBEEF, data_rvalid_o=0.
- Contention right after reset: both req asserted continuously, mem always grants -> grant sequence DATA, INSTR, DATA, INSTR.
- Backpressure: MAX_OUTSTANDING=2, mem_gnt_i=1, rvalid withheld:
  - after 2 grants mem_req_o=0 and outstanding_o=2;
  - one rvalid -> mem_req_o returns the following cycle.
- In-order routing: issue INSTR, DATA, INSTR; return 3 rvalids with rdata 0x1, 0x2, 0x3 -> instr receives 0x1 and 0x3, data receives 0x2.
- Spurious response: rvalid with FIFO empty -> err_o=1, stays 1 until rst_i; no x_rvalid_o asserted.
- Reset mid-flight: 2 outstanding, assert rst_i for 1 cycle -> outstanding_o=0, err_o=0, next contention grants DATA first.
